// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the RV32M sequencer.
// The execute stage drives the request side; the sequencer returns status and result.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in, flush,
        input  busy, stall, done, result, rd_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in, flush,
        output busy, stall, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: one registered multiply or an XLEN-step restoring
// divide per request, stalling the pipeline until the result and rd are returned.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);
    localparam int              CW        = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_divisor;
    logic [2:0]      r_f3;
    logic [4:0]      r_rd;
    logic            r_divz;
    logic            r_ovf;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd_out;

    logic            w_accept;
    logic            w_in_signed;
    logic            w_in_divz;
    logic            w_in_ovf;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;

    logic            w_a_sx;
    logic            w_b_sx;
    logic [2*XLEN-1:0] w_mul_a;
    logic [2*XLEN-1:0] w_mul_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_mul_half;

    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_keep;

    logic            w_q_neg;
    logic            w_r_neg;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_final;

    // Requests are refused during the done cycle so a held start is not taken twice.
    assign w_accept    = (r_state == S_IDLE) & bus.start & ~bus.flush & ~r_done;
    assign w_in_signed = ~bus.funct3[0];
    assign w_in_divz   = (bus.op_b == '0);
    assign w_in_ovf    = w_in_signed & (bus.op_a == MIN_NEG) & (&bus.op_b);
    assign w_a_mag     = (w_in_signed & bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
    assign w_b_mag     = (w_in_signed & bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;

    // MULHU treats both operands as unsigned, MULHSU only the second.
    assign w_a_sx     = (r_f3[1:0] != 2'b11);
    assign w_b_sx     = ~r_f3[1];
    assign w_mul_a    = {{XLEN{w_a_sx & r_a[XLEN-1]}}, r_a};
    assign w_mul_b    = {{XLEN{w_b_sx & r_b[XLEN-1]}}, r_b};
    assign w_prod     = w_mul_a * w_mul_b;
    assign w_mul_half = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // The dividend shifts out of the quotient register as quotient bits shift in.
    assign w_rem_sh = {r_rem, r_quot[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_divisor};
    assign w_keep   = ~w_diff[XLEN];

    assign w_q_neg = ~r_f3[0] & (r_a[XLEN-1] ^ r_b[XLEN-1]);
    assign w_r_neg = ~r_f3[0] & r_a[XLEN-1];
    assign w_q_fix = w_q_neg ? -r_quot : r_quot;
    assign w_r_fix = w_r_neg ? -r_rem : r_rem;

    always_comb begin
        w_final = r_quot;
        if (r_f3[2]) begin
            if (r_divz) begin
                w_final = r_f3[1] ? r_a : '1;
            end else if (r_ovf) begin
                w_final = r_f3[1] ? '0 : MIN_NEG;
            end else begin
                w_final = r_f3[1] ? w_r_fix : w_q_fix;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!bus.funct3[2]) begin
                        w_state_next = S_MUL;
                    end else if (w_in_divz || w_in_ovf) begin
                        w_state_next = S_FIN;
                    end else begin
                        w_state_next = S_DIV;
                    end
                end
            end
            S_MUL:   w_state_next = S_FIN;
            S_DIV:   if (r_cnt == LAST_ITER) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (bus.flush && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_f3      <= '0;
            r_rd      <= '0;
            r_divz    <= 1'b0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_rd_out  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a       <= bus.op_a;
                        r_b       <= bus.op_b;
                        r_f3      <= bus.funct3;
                        r_rd      <= bus.rd_in;
                        r_divz    <= w_in_divz;
                        r_ovf     <= w_in_ovf;
                        r_quot    <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_MUL: begin
                    r_quot <= w_mul_half;
                end
                S_DIV: begin
                    r_rem  <= w_keep ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                    r_quot <= {r_quot[XLEN-2:0], w_keep};
                    r_cnt  <= r_cnt + 1'b1;
                end
                S_FIN: begin
                    if (!bus.flush) begin
                        r_done   <= 1'b1;
                        r_result <= w_final;
                        r_rd_out <= r_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.stall  = (bus.start | bus.busy) & ~r_done;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, random ops against an
// arithmetic reference model, and hand sequences for back-to-back, flush and reset.
module tb_muldiv_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] last_exp;

    muldiv_seq_if #(.XLEN(32)) bus();

    muldiv_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        longint p;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Counts edges until done is seen; optionally pulses start with junk while busy.
    task automatic wait_done(input bit noise, output int lat, output bit stall_ok);
        lat = 0;
        stall_ok = 1'b1;
        forever begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done) break;
            if (!bus.stall) stall_ok = 1'b0;
            if (noise) begin
                bus.start = (lat == 5);
                if (lat == 5) begin
                    bus.funct3 = 3'($urandom_range(0, 7));
                    bus.op_a   = $urandom;
                    bus.op_b   = $urandom;
                    bus.rd_in  = 5'($urandom_range(0, 31));
                end
            end
            if (lat >= 100) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_lat, input bit noise);
        int lat;
        bit stall_ok;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(noise, lat, stall_ok);
        $display("op %s f3=%0d a=%h b=%h rd=%0d result=%h rd_out=%0d lat=%0d",
                 name, f3, a, b, rd, bus.result, bus.rd_out, lat);
        chk({name, " result"}, bus.result, exp);
        chk({name, " rd_out"}, 32'(bus.rd_out), 32'(rd));
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " stall while busy"}, 32'(stall_ok), 32'd1);
        chk({name, " stall in done cycle"}, 32'(bus.stall), 32'd0);
        chk({name, " busy in done cycle"}, 32'(bus.busy), 32'd0);
        last_exp = exp;
    endtask

    initial begin
        int lat;
        bit stall_ok;
        int ndone;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        checks = 0;
        errors = 0;
        last_exp = 32'd0;

        vecs.push_back('{3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 2});
        vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 2});
        vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 2});
        vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 2});
        vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33});
        vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33});
        vecs.push_back('{3'd5, 32'd100,      32'd7,        5'd11, 32'd14,       33});
        vecs.push_back('{3'd7, 32'd100,      32'd7,        5'd12, 32'd2,        33});
        vecs.push_back('{3'd5, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1});
        vecs.push_back('{3'd7, 32'd5,        32'd0,        5'd14, 32'd5,        1});
        vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1});
        vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1});
        vecs.push_back('{3'd4, 32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, 1});
        vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd0,        5'd18, 32'hFFFFFFF9, 1});

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd0;
        bus.op_b   = 32'd0;
        bus.rd_in  = 5'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset rd_out", 32'(bus.rd_out), 32'd0);
        chk("reset stall", 32'(bus.stall), 32'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
                   vecs[i].exp, vecs[i].lat, 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = rnd_operand();
            b  = rnd_operand();
            run_op($sformatf("rnd%0d", i), f3, a, b, 5'($urandom_range(0, 31)),
                   ref_result(f3, a, b), ref_latency(f3, a, b), (i % 4) == 0);
        end

        // Back-to-back: start stays high across the done cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.rd_in = 5'd3;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        $display("op b2b-divu result=%h lat=%0d", bus.result, lat);
        chk("b2b first result", bus.result, 32'd14);
        chk("b2b first latency", 32'(lat), 32'd33);
        chk("b2b stall in done cycle", 32'(bus.stall), 32'd0);
        bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.rd_in = 5'd9;
        @(posedge clk);
        @(negedge clk);
        chk("b2b no re-accept in done cycle", 32'(bus.busy), 32'd0);
        chk("b2b stall while waiting", 32'(bus.stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b second accepted", 32'(bus.busy), 32'd1);
        wait_done(1'b0, lat, stall_ok);
        $display("op b2b-mul result=%h rd_out=%0d lat=%0d", bus.result, bus.rd_out, lat);
        chk("b2b second result", bus.result, 32'd12);
        chk("b2b second rd_out", 32'(bus.rd_out), 32'd9);
        chk("b2b second latency", 32'(lat), 32'd2);
        last_exp = 32'd12;

        // flush together with start in IDLE is not an accept.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd2; bus.op_b = 32'd2;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush+start idle no accept", 32'(bus.busy), 32'd0);
        $display("op flush-idle busy=%0d", bus.busy);

        // flush on iteration 10 of a divide.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.rd_in = 5'd20;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush busy", 32'(bus.busy), 32'd0);
        chk("flush done", 32'(bus.done), 32'd0);
        chk("flush result held", bus.result, last_exp);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("flush no late done", 32'(ndone), 32'd0);
        $display("op flush-div result=%h late_done=%0d", bus.result, ndone);
        run_op("post-flush mul", 3'd0, 32'd6, 32'd7, 5'd21, 32'd42, 2, 1'b0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd1000; bus.op_b = 32'd7; bus.rd_in = 5'd22;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset busy", 32'(bus.busy), 32'd0);
        chk("async reset done", 32'(bus.done), 32'd0);
        chk("async reset result", bus.result, 32'd0);
        chk("async reset rd_out", 32'(bus.rd_out), 32'd0);
        chk("async reset stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("reset no late done", 32'(ndone), 32'd0);
        $display("op reset-div late_done=%0d", ndone);
        run_op("post-reset div", 3'd4, 32'd9, 32'd3, 5'd23, 32'd3, 33, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M operations that the decode stage flags with is_m_ext_o.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request at a time.
- Runs a registered multiply or a restoring radix-2 divide loop, and stalls the pipeline until the result is returned with its rd address.
- Sits beside the ALU in the execute stage.

Parameters:
XLEN, 32, operand/result width; divide loop runs XLEN iterations

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  M-extension instruction present in execute (is_m_ext_o)
funct3  input  3  operation select per RV32M encoding
op_a  input  XLEN  rs1 value / dividend
op_b  input  XLEN  rs2 value / divisor
rd_in  input  5  destination register of the request
flush  input  1  synchronous abort (branch/trap redirect)
busy  output  1  operation in flight
stall  output  1  hold upstream pipeline
done  output  1  one-cycle result-valid pulse
result  output  XLEN  result, held until next accept
rd_out  output  5  destination register paired with result

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); clock is clk.
- Reset values: state=IDLE, busy=0, done=0, result=0, rd_out=0, iteration counter=0.
- States:
  - IDLE, MUL, DIV, FIN.
  - busy = (state != IDLE).
  - done and result are registers written on the FIN→IDLE edge.
- Accept condition: state==IDLE & start & ~flush & ~done. On accept, latch operands, funct3 and rd_in.
- Transitions from IDLE on accept:
  - funct3[2]=0 → MUL.
  - Divide by zero, or signed overflow (funct3=100/110, op_a=0x80000000, op_b=0xFFFFFFFF) → FIN directly.
  - Other divides → DIV.
- MUL:
  - Form the 2*XLEN product with signedness from funct3: 000/001 signed×signed, 010 signed×unsigned, 011 unsigned×unsigned.
  - 000 selects low half; others select high half.
  - → FIN.
- DIV:
  - Signed ops (funct3[0]=0) divide magnitudes.
  - One restoring step per cycle: shift remainder left, subtract divisor, keep if non-negative, set quotient bit.
  - Counter 0..XLEN-1; at XLEN-1 → FIN.
- FIN:
  - Signed sign fixup: quotient negated if operand signs differ; remainder takes dividend sign.
  - funct3[1] selects remainder.
  - Special cases: divide by zero gives quotient all-ones and remainder = op_a; overflow gives quotient 0x80000000 and remainder 0.
  - → IDLE, done=1, result/rd_out updated.
- Latency, counted as edges after the accept edge E0 until done is high:
  - Special divide: 1.
  - MUL: 2.
  - DIV: XLEN+1 (33).
- done is high exactly one cycle; state is IDLE during it.
- stall = (start | busy) & ~done, combinational. The pipeline advances in the done cycle. start held high in that cycle is not re-accepted; a new request is accepted the following cycle.
- start while busy: ignored, no effect on the operation in flight.
- flush:
  - In any non-IDLE state: next edge → IDLE, done stays 0, result unchanged.
  - flush with start in IDLE: no accept.
  - flush in FIN: takes priority, so no done.
- rst_n low mid-operation: immediate return to reset values; no done after release.
- All arithmetic is modulo 2^XLEN; unsigned ops ignore sign bits.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3), rd=5 → done exactly 2 edges after accept, result=0xFFFFFFEB, rd_out=5; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000.
- DIV 0xFFFFFFF9 (-7) / 2 → done after 33 edges, result 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2; stall high throughout and 0 in the done cycle.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with latency 1; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, latency 1.
- Back-to-back: start held high across the done cycle → no re-accept in the done cycle; a new start in the next cycle is accepted and completes normally; start pulses while busy are ignored.
- flush asserted on iteration 10 of a DIV → busy=0 next cycle, no done pulse, result keeps its prior value; a following MUL completes correctly.
- rst_n pulsed low mid-DIV → all outputs zero asynchronously; after release, no done appears and a fresh DIV 9/3 returns 3 after 33 edges.
